// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment read-back monitor.
// Segment patterns are active-low: bit 6 = g ... bit 0 = a, 0 = segment lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {S_WAIT, S_LOCK} reader_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder from an active-low segment pattern to a BCD digit.
// Anything that is neither a digit code nor blank reports is_digit = is_blank = 0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  // Table lookup; digit is 0 whenever the pattern is not a legal digit code.
  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounced seven-segment read-back monitor. A pattern is classified only
// after it has been sampled unchanged for STABLE_CYCLES consecutive edges.
//
// Output semantics: digit_valid is a single-cycle strobe with no back-pressure;
// it fires on the edge a digit pattern locks and digit carries the decoded value
// from that same edge onward. stable/blank/invalid are levels that hold for the
// whole time the locked pattern stays on the bus. state exposes the FSM.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    leds,
  output logic [3:0]    digit,
  output logic          digit_valid,
  output logic          stable,
  output logic          blank,
  output logic          invalid,
  output logic [7:0]    lock_count,
  output reader_state_t state
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0] leds_q;
  logic [7:0] cnt;
  logic       same;
  logic [3:0] dec_digit;
  logic       dec_is_digit;
  logic       dec_is_blank;

  assign same = (leds == leds_q);

  // The locked pattern always equals leds_q on the lock edge, so decode the register.
  seg7_decode u_decode (
    .pattern  (leds_q),
    .digit    (dec_digit),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  // Sample register and saturating run-length counter of identical samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= SEG_BLANK;
      cnt    <= 8'd0;
    end else begin
      leds_q <= leds;
      if (!same)
        cnt <= 8'd0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  // WAIT/LOCK state machine with registered classification outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      stable      <= 1'b0;
      blank       <= 1'b0;
      invalid     <= 1'b0;
      lock_count  <= 8'd0;
    end else begin
      digit_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (same && cnt == CNT_MAX) begin
            state  <= S_LOCK;
            stable <= 1'b1;
            if (dec_is_digit) begin
              digit       <= dec_digit;
              digit_valid <= 1'b1;
              if (lock_count != 8'hFF)
                lock_count <= lock_count + 8'd1;
            end else if (dec_is_blank) begin
              blank <= 1'b1;
            end else begin
              invalid <= 1'b1;
            end
          end
        end
        S_LOCK: begin
          // Any change releases the lock; digit keeps the last decoded value.
          if (!same) begin
            state   <= S_WAIT;
            stable  <= 1'b0;
            blank   <= 1'b0;
            invalid <= 1'b0;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus random pattern runs, all
// compared every cycle against a behavioural model of the lock rules.
module tb_seg7_reader;
  import seg7_pkg::*;

  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    leds;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          stable;
  logic          blank;
  logic          invalid;
  logic [7:0]    lock_count;
  reader_state_t state;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .leds        (leds),
    .digit       (digit),
    .digit_valid (digit_valid),
    .stable      (stable),
    .blank       (blank),
    .invalid     (invalid),
    .lock_count  (lock_count),
    .state       (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Digit codes written out literally so the model is independent of the package.
  logic [6:0] ref_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] pkg_codes [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                 SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

  // Behavioural model state.
  logic [6:0] m_prev;
  int         m_run;
  bit         m_locked;
  int         m_digit;
  bit         m_dv, m_stable, m_blank, m_inv;
  int         m_lc;

  function automatic int code_index(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (ref_codes[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock edge of the model: run = number of repeats seen of the current sample.
  task automatic model_edge(input logic [6:0] p, input logic r);
    int idx;
    bit same;
    if (r) begin
      m_prev = 7'h7F; m_run = 0; m_locked = 0; m_digit = 0;
      m_dv = 0; m_stable = 0; m_blank = 0; m_inv = 0; m_lc = 0;
    end else begin
      same = (p == m_prev);
      m_dv = 0;
      if (!m_locked && same && m_run >= SC - 1) begin
        m_locked = 1;
        m_stable = 1;
        idx = code_index(p);
        if (idx >= 0) begin
          m_digit = idx;
          m_dv = 1;
          if (m_lc < 255) m_lc++;
        end else if (p == 7'h7F) m_blank = 1;
        else m_inv = 1;
      end else if (m_locked && !same) begin
        m_locked = 0; m_stable = 0; m_blank = 0; m_inv = 0;
      end
      m_run  = same ? m_run + 1 : 0;
      m_prev = p;
    end
  endtask

  task automatic check_all();
    logic [31:0] obs, exp;
    obs = {15'd0, (state == S_LOCK), digit, digit_valid, stable, blank, invalid, lock_count};
    exp = {15'd0, m_locked, 4'(m_digit), m_dv, m_stable, m_blank, m_inv, 8'(m_lc)};
    check("outputs", obs, exp);
  endtask

  // Drive one cycle, advance the model on the edge, compare on the falling edge.
  task automatic step(input logic [6:0] p, input logic r);
    leds  = p;
    reset = r;
    @(posedge clk);
    model_edge(p, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    step(7'h7F, 1'b1);
    step(7'h7F, 1'b1);
  endtask

  initial begin
    int lock_at;
    int pulses;
    int hold;
    logic [6:0] p;
    bit exp_inv;

    reset = 1'b1;
    leds  = 7'h7F;

    // Reset state.
    do_reset();
    check("reset_state", {digit, digit_valid, stable, blank, invalid, lock_count}, 16'h0);

    // Digit 1 locks exactly four edges after it is first sampled.
    lock_at = -1;
    for (int i = 0; i < 6; i++) begin
      step(7'h79, 1'b0);
      if (digit_valid === 1'b1 && lock_at < 0) lock_at = i;
    end
    check("lock_latency", lock_at, 4);
    check("digit_one", digit, 4'd1);
    check("lock_count_one", lock_count, 8'd1);

    // Glitch on a locked digit: drops stable, glitch never locks, relock pulses again.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin step(7'h24, 1'b0); pulses += digit_valid; end
    step(7'h30, 1'b0);
    check("glitch_drops_stable", stable, 1'b0);
    step(7'h30, 1'b0);
    for (int i = 0; i < 6; i++) begin step(7'h24, 1'b0); pulses += digit_valid; end
    check("glitch_pulses", pulses, 2);
    check("glitch_lock_count", lock_count, 8'd2);
    check("glitch_digit", digit, 4'd2);

    // Blank after a digit, then an invalid pattern.
    do_reset();
    for (int i = 0; i < 6; i++) step(7'h12, 1'b0);
    for (int i = 0; i < 6; i++) step(7'h7F, 1'b0);
    check("blank_flags", {blank, stable, invalid, digit}, {1'b1, 1'b1, 1'b0, 4'd5});
    for (int i = 0; i < 6; i++) step(7'h55, 1'b0);
    check("invalid_flags", {blank, stable, invalid, digit}, {1'b0, 1'b1, 1'b1, 4'd5});

    // Alternating 0/9 until lock_count saturates.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 6; i++) step(7'h40, 1'b0);
      for (int i = 0; i < 6; i++) step(7'h10, 1'b0);
    end
    check("lock_count_sat", lock_count, 8'd255);
    check("alt_digit", digit, 4'd9);

    // Reset with cnt = 2, then reset while locked.
    do_reset();
    for (int i = 0; i < 3; i++) step(7'h19, 1'b0);
    step(7'h19, 1'b1);
    check("reset_midcount", {digit, digit_valid, stable, blank, invalid, lock_count}, 16'h0);
    for (int i = 0; i < 5; i++) step(7'h19, 1'b0);
    check("relocked_four", {stable, digit}, {1'b1, 4'd4});
    step(7'h19, 1'b1);
    check("reset_in_lock", {digit, digit_valid, stable, blank, invalid, lock_count}, 16'h0);
    step(7'h19, 1'b0);

    // All ten package codes decode to their digit.
    do_reset();
    for (int d = 0; d < 10; d++) begin
      for (int i = 0; i < SC + 1; i++) step(pkg_codes[d], 1'b0);
      check($sformatf("code_%0d", d), {digit_valid, digit}, {1'b1, 4'(d)});
    end

    // Exhaustive sweep: everything but the ten codes and blank is invalid.
    do_reset();
    for (int c = 0; c < 128; c++) begin
      p = 7'(c);
      for (int i = 0; i < SC + 1; i++) step(p, 1'b0);
      exp_inv = (code_index(p) < 0) && (p != 7'h7F);
      check($sformatf("sweep_%02h", p), invalid, exp_inv);
    end

    // Random holds of random patterns, with occasional resets.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    p = ref_codes[$urandom_range(0, 9)];
        2:       p = 7'h7F;
        default: p = 7'($urandom_range(0, 127));
      endcase
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) step(p, ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
